differentiate: RTL and testbench



---
 rtl/differentiate.sv | 92 +++++++++
 tb/tb_differentiate.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/differentiate.sv
// differentiate: turns a stream of running sums back into per-step differences.
// Optional clamping on overflow is enabled by defining DIFFERENTIATE_SATURATE_EN.
module differentiate #(
   parameter int ARGW = 24,
   parameter int RESW = 40
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic [RESW-1:0] arg_data,
   input  logic            arg_valid,
   output logic            arg_ready,
   output logic [ARGW-1:0] res_data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            res_ovf
);

   localparam logic [ARGW-1:0] MAXV = {1'b0, {(ARGW-1){1'b1}}};
   localparam logic [ARGW-1:0] MINV = {1'b1, {(ARGW-1){1'b0}}};

   logic [RESW-1:0]   prev;
   logic [RESW-1:0]   base;
   logic [RESW-1:0]   diff;
   logic [RESW-ARGW:0] upper;
   logic              ovf;
   logic [ARGW-1:0]   val;
   logic [ARGW-1:0]   skid_data;
   logic              skid_ovf;
   logic              skid_full;
   logic              in_fire;
   logic              out_free;

   assign arg_ready = !skid_full;
   assign in_fire   = arg_valid && !skid_full;
   assign out_free  = !res_valid || res_ready;

   // Difference against the previous sum; overflow when the bits above the
   // ARGW sign bit are not a pure sign extension.
   always_comb begin
      base  = clr ? '0 : prev;
      diff  = arg_data - base;
      upper = diff[RESW-1:ARGW-1];
      ovf   = !((&upper) || !(|upper));
`ifdef DIFFERENTIATE_SATURATE_EN
      if (ovf)
         val = diff[RESW-1] ? MINV : MAXV;
      else
         val = diff[ARGW-1:0];
`else
      val = diff[ARGW-1:0];
`endif
   end

   // Previous-sum register, updated on every accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prev <= '0;
      else if (in_fire)
         prev <= arg_data;
   end

   // Output register with a one-entry skid buffer behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= '0;
         res_ovf   <= 1'b0;
         res_valid <= 1'b0;
         skid_data <= '0;
         skid_ovf  <= 1'b0;
         skid_full <= 1'b0;
      end else if (out_free) begin
         if (skid_full) begin
            res_data  <= skid_data;
            res_ovf   <= skid_ovf;
            res_valid <= 1'b1;
            skid_full <= 1'b0;
         end else if (in_fire) begin
            res_data  <= val;
            res_ovf   <= ovf;
            res_valid <= 1'b1;
         end else begin
            res_valid <= 1'b0;
         end
      end else if (in_fire) begin
         skid_data <= val;
         skid_ovf  <= ovf;
         skid_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_differentiate.sv
// tb_differentiate: directed stimulus with a reference model and per-cycle
// output checking for the differentiate block.
module tb_differentiate;

   localparam int ARGW = 24;
   localparam int RESW = 40;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr = 1'b0;
   logic [RESW-1:0] arg_data = '0;
   logic            arg_valid = 1'b0;
   logic            arg_ready;
   logic [ARGW-1:0] res_data;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic            res_ovf;

   differentiate #(.ARGW(ARGW), .RESW(RESW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .res_ovf(res_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ARGW-1:0] d;
      logic            o;
      int              cyc;
      logic            free;
   } exp_t;

   exp_t            q[$];
   logic [ARGW-1:0] log_d[$];
   logic            log_o[$];
   logic [RESW-1:0] mprev = '0;
   int              cyc = 0;
   logic            shown = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: difference of full-precision sums, range test on the signed value.
   function automatic exp_t model(input logic [RESW-1:0] a, input logic c);
      exp_t e;
      logic [RESW-1:0] b;
      logic [RESW-1:0] d;
      longint dv;
      b  = c ? '0 : mprev;
      d  = a - b;
      dv = longint'($signed(d));
      e.o = (dv > 64'sd8388607) || (dv < -64'sd8388608);
`ifdef DIFFERENTIATE_SATURATE_EN
      if (e.o) e.d = (dv > 0) ? 24'h7fffff : 24'h800000;
      else e.d = d[ARGW-1:0];
`else
      e.d = d[ARGW-1:0];
`endif
      e.cyc = 0;
      e.free = 1'b0;
      return e;
   endfunction

   // Per-cycle compare of the DUT outputs against the model queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         mprev = '0;
         shown = 1'b0;
      end else begin
         cyc++;
         if (res_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               if (!shown) begin
                  shown = 1'b1;
                  if (q[0].free) chk("latency", cyc, q[0].cyc + 1);
               end
               chk("res_data", res_data, q[0].d);
               chk("res_ovf", res_ovf, q[0].o);
               if (res_ready) begin
                  log_d.push_back(res_data);
                  log_o.push_back(res_ovf);
                  void'(q.pop_front());
                  shown = 1'b0;
               end
            end
         end
         if (arg_valid && arg_ready) begin
            e = model(arg_data, clr);
            e.cyc = cyc;
            e.free = !res_valid || res_ready;
            mprev = arg_data;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [RESW-1:0] v, input logic c);
      logic acc;
      int n;
      arg_data = v;
      clr = c;
      arg_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = arg_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 0, 1);
      arg_valid = 1'b0;
      clr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || res_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", n < 100, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_log(input int i, input logic [ARGW-1:0] d, input logic o);
      if (i >= log_d.size()) begin
         chk("log_missing", i, log_d.size());
      end else begin
         chk("log_data", log_d[i], d);
         chk("log_ovf", log_o[i], o);
      end
   endtask

   int b;

   initial begin
      #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_ovf", res_ovf, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_ready", arg_ready, 1);

      b = log_d.size();
      send(40'h00ff, 1'b0);
      send(40'h0100, 1'b0);
      send(40'h00ff, 1'b0);
      send(40'h000f, 1'b1);
      drain();
      chk_log(b + 0, 24'h0000ff, 1'b0);
      chk_log(b + 1, 24'h000001, 1'b0);
      chk_log(b + 2, 24'hffffff, 1'b0);
      chk_log(b + 3, 24'h00000f, 1'b0);

      do_reset();
      b = log_d.size();
      send(40'h0000800000, 1'b0);
      send(40'hff_ff00_0000, 1'b0);
      drain();
`ifdef DIFFERENTIATE_SATURATE_EN
      chk_log(b + 0, 24'h7fffff, 1'b1);
`else
      chk_log(b + 0, 24'h800000, 1'b1);
`endif
      chk_log(b + 1, 24'h800000, 1'b1);

      b = log_d.size();
      res_ready = 1'b0;
      fork
         begin
            send(40'd1, 1'b1);
            send(40'd3, 1'b0);
            send(40'd6, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            chk("bp_ready_low", arg_ready, 0);
            chk("bp_hold_data", res_data, 1);
            chk("bp_hold_valid", res_valid, 1);
            res_ready = 1'b1;
         end
      join
      drain();
      chk_log(b + 0, 24'd1, 1'b0);
      chk_log(b + 1, 24'd2, 1'b0);
      chk_log(b + 2, 24'd3, 1'b0);

      b = log_d.size();
      for (int i = 1; i <= 16; i++) send(RESW'(7 * i), i == 1);
      drain();
      chk("tp_count", log_d.size() - b, 16);
      for (int i = 0; i < 16; i++) chk_log(b + i, 24'd7, 1'b0);

      res_ready = 1'b0;
      send(40'd5, 1'b1);
      send(40'd9, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_ready", arg_ready, 1);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      res_ready = 1'b1;
      b = log_d.size();
      send(40'd4, 1'b0);
      drain();
      chk_log(b + 0, 24'h000004, 1'b0);

      b = log_d.size();
      send(40'h0100, 1'b1);
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      send(40'h0105, 1'b0);
      drain();
      chk_log(b + 0, 24'h000100, 1'b0);
      chk_log(b + 1, 24'h000005, 1'b0);

      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
